// File: rtl/score_digits_bitmap.sv
// Multi-digit score renderer for the VGA object chain.
// A binary score is saturated, converted to BCD by a sequential double-dabble
// engine, committed atomically to the display digits and drawn as scaled 8x16
// glyphs through a 2-stage pixel pipeline.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   score, score_load           binary score and 1-cycle conversion strobe
//   offsetX, offsetY            pixel offset from the object's top-left corner
//   InsideRectangle             pixel lies within the object bracket
//   busy, done, overflow        converter status (done is a 1-cycle commit pulse)
//   drawingRequest, RGBout      pixel output pair for the object mux
module score_digits_bitmap #(
  parameter int unsigned NUM_DIGITS           = 4,
  parameter int unsigned SCORE_WIDTH          = 14,
  parameter int unsigned SCALE_SHIFT          = 1,
  parameter int unsigned BLANK_LEADING        = 1,
  parameter logic [7:0]  TEXT_COLOR           = 8'hFF,
  parameter logic [7:0]  TRANSPARENT_ENCODING = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SCORE_WIDTH-1:0] score,
  input  logic                   score_load,
  input  logic [10:0]            offsetX,
  input  logic [10:0]            offsetY,
  input  logic                   InsideRectangle,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   drawingRequest,
  output logic [7:0]             RGBout
);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  localparam int unsigned BCD_W    = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W    = $clog2(SCORE_WIDTH + 1);
  localparam int unsigned MAXV     = pow10(NUM_DIGITS) - 1;
  localparam int unsigned MAXV_W   = $clog2(MAXV + 1);
  localparam int unsigned CMP_W    = (SCORE_WIDTH > MAXV_W) ? SCORE_WIDTH : MAXV_W;
  localparam int unsigned CELL_H   = 16 << SCALE_SHIFT;
  localparam int unsigned DI_SHIFT = 3 + SCALE_SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_e;

  state_e                 state_q, state_d;
  logic [SCORE_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]       shadow_q, shadow_d;
  logic [BCD_W-1:0]       disp_q, disp_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_next_q, ovf_next_d;
  logic                   overflow_q, overflow_d;
  logic                   pending_q, pending_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Converter state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Converter next-state; a strobe landing in COMMIT restarts immediately
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (score_load) state_d = S_SHIFT;
      S_SHIFT:  if (cnt_q == CNT_W'(1)) state_d = S_COMMIT;
      S_COMMIT: state_d = (pending_q || score_load) ? S_SHIFT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Converter status outputs, registered from the next state
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_COMMIT);
  end

  logic                   start_c;
  logic                   ovf_c;
  logic [SCORE_WIDTH-1:0] sat_c;
  logic [BCD_W-1:0]       adj_c;

  // Double-dabble datapath, saturation and pending-load bookkeeping
  always_comb begin
    bin_d      = bin_q;
    shadow_d   = shadow_q;
    disp_d     = disp_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    overflow_d = overflow_q;
    pending_d  = pending_q;

    ovf_c   = CMP_W'(score) > CMP_W'(MAXV);
    sat_c   = ovf_c ? SCORE_WIDTH'(MAXV) : score;
    start_c = (state_q == S_IDLE   && score_load) ||
              (state_q == S_COMMIT && (pending_q || score_load));

    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      adj_c[4*i +: 4] = (shadow_q[4*i +: 4] >= 4'd5) ? shadow_q[4*i +: 4] + 4'd3
                                                      : shadow_q[4*i +: 4];
    end

    if (start_c) begin
      bin_d      = sat_c;
      shadow_d   = '0;
      cnt_d      = CNT_W'(SCORE_WIDTH);
      ovf_next_d = ovf_c;
    end else if (state_q == S_SHIFT) begin
      shadow_d = {adj_c[BCD_W-2:0], bin_q[SCORE_WIDTH-1]};
      bin_d    = {bin_q[SCORE_WIDTH-2:0], 1'b0};
      cnt_d    = cnt_q - CNT_W'(1);
    end

    if (state_q == S_COMMIT) begin
      disp_d     = shadow_q;
      overflow_d = ovf_next_q;
    end

    case (state_q)
      S_SHIFT: pending_d = pending_q || score_load;
      default: pending_d = 1'b0;
    endcase
  end

  // Converter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q      <= '0;
      shadow_q   <= '0;
      disp_q     <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      shadow_q   <= shadow_d;
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Glyph bitmaps: row 0 in the top byte, column 0 in each byte's MSB
  function automatic logic [127:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 128'h00003C66666666666666663C00000000;
      4'd1:    return 128'h00001838781818181818187E00000000;
      4'd2:    return 128'h00003C6606060C183060667E00000000;
      4'd3:    return 128'h00003C6606061C060606663C00000000;
      4'd4:    return 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
      4'd5:    return 128'h00007E6060607C060606663C00000000;
      4'd6:    return 128'h00001C3060607C666666663C00000000;
      4'd7:    return 128'h00007E6606060C183030303000000000;
      4'd8:    return 128'h00003C6666663C666666663C00000000;
      4'd9:    return 128'h00003C6666663E0606060C3800000000;
      default: return 128'h0;
    endcase
  endfunction

  logic [10:0] di_c;
  logic [2:0]  gc_c;
  logic [3:0]  gr_c;
  logic        valid_c;
  logic [3:0]  dig_c;
  logic        lead_zero_c;
  logic        valid_q;
  logic [3:0]  dig_q;
  logic [2:0]  gc_q;
  logic [3:0]  gr_q;

  // Pixel stage 1: cell decode and digit select with leading-zero blanking
  always_comb begin
    di_c        = offsetX >> DI_SHIFT;
    gc_c        = 3'(offsetX >> SCALE_SHIFT);
    gr_c        = 4'(offsetY >> SCALE_SHIFT);
    valid_c     = InsideRectangle && (di_c < 11'(NUM_DIGITS)) && (offsetY < 11'(CELL_H));
    dig_c       = 4'd0;
    lead_zero_c = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      lead_zero_c = lead_zero_c && (disp_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      if (di_c == 11'(i)) begin
        dig_c = disp_q[4*(NUM_DIGITS-1-i) +: 4];
        if (BLANK_LEADING != 0 && lead_zero_c && i != NUM_DIGITS - 1) dig_c = 4'hF;
      end
    end
  end

  logic [127:0] glyph_c;
  logic [6:0]   bit_idx_c;
  logic [7:0]   rgb_d, rgb_q;
  logic         draw_d, draw_q;

  // Pixel stage 2: font lookup and colour
  always_comb begin
    glyph_c   = glyph(dig_q);
    bit_idx_c = ~{gr_q, gc_q};
    rgb_d     = (valid_q && glyph_c[bit_idx_c]) ? TEXT_COLOR : TRANSPARENT_ENCODING;
    draw_d    = (rgb_d != TRANSPARENT_ENCODING);
  end

  // Pixel pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      dig_q   <= 4'd0;
      gc_q    <= 3'd0;
      gr_q    <= 4'd0;
      rgb_q   <= TRANSPARENT_ENCODING;
      draw_q  <= 1'b0;
    end else begin
      valid_q <= valid_c;
      dig_q   <= dig_c;
      gc_q    <= gc_c;
      gr_q    <= gr_c;
      rgb_q   <= rgb_d;
      draw_q  <= draw_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign RGBout         = rgb_q;
  assign drawingRequest = draw_q;

endmodule
